// File: rtl/sram_arbiter2_if.sv
// Bus bundle between the two requesters, the arbiter and the 8x32 SRAM.
// The slave view belongs to the arbiter; the master view belongs to the
// requesters and the SRAM array that sit around it.
interface sram_arbiter2_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [2:0]        addr0;
  logic [2:0]        addr1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [2:0]        sram_addr;
  logic              sram_we;
  logic [DATA_W-1:0] sram_wd;
  logic [DATA_W-1:0] sram_rd;
  logic              busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wd0, wd1, sram_rd,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
    output sram_addr, sram_we, sram_wd, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wd0, wd1, sram_rd,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
    input  sram_addr, sram_we, sram_wd, busy
  );
endinterface

// File: rtl/sram_arbiter2.sv
// Two-port round-robin arbiter in front of a single-port 8x32 SRAM.
// Each access takes IDLE -> ISSUE -> COMPLETE: the grant pulse marks ISSUE,
// writes land at the edge ending ISSUE, reads are captured at the edge
// ending COMPLETE, and done pulses in the first IDLE cycle afterwards.
module sram_arbiter2 #(
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t            state;
  logic              last;       // port served most recently (1 = port 1)
  logic              win_p0;     // port owning the access in flight
  logic              wr_p0;
  logic [2:0]        addr_p0;
  logic [DATA_W-1:0] wd_p0;
  logic              we_n_p1;
  logic              gnt0_p1;
  logic              gnt1_p1;
  logic              done0_p1;
  logic              done1_p1;
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;
  logic              busy_p1;

  logic              any_req;
  logic              pick;

  // Round-robin choice: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick    = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last;
    end else begin
      pick = bus.req1;
    end
  end

  // Access sequencer: latches the winner's payload, pulses grant/done, captures read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      win_p0    <= 1'b0;
      wr_p0     <= 1'b0;
      addr_p0   <= 3'd0;
      wd_p0     <= '0;
      we_n_p1   <= 1'b1;
      gnt0_p1   <= 1'b0;
      gnt1_p1   <= 1'b0;
      done0_p1  <= 1'b0;
      done1_p1  <= 1'b0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
      busy_p1   <= 1'b0;
    end else begin
      gnt0_p1  <= 1'b0;
      gnt1_p1  <= 1'b0;
      done0_p1 <= 1'b0;
      done1_p1 <= 1'b0;
      we_n_p1  <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ISSUE;
            busy_p1 <= 1'b1;
            win_p0  <= pick;
            last    <= pick;
            wr_p0   <= pick ? bus.wr1   : bus.wr0;
            addr_p0 <= pick ? bus.addr1 : bus.addr0;
            wd_p0   <= pick ? bus.wd1   : bus.wd0;
            we_n_p1 <= pick ? ~bus.wr1  : ~bus.wr0;
            gnt0_p1 <= ~pick;
            gnt1_p1 <= pick;
          end
        end
        ISSUE: begin
          state <= COMPLETE;
        end
        COMPLETE: begin
          state   <= IDLE;
          busy_p1 <= 1'b0;
          if (win_p0) begin
            done1_p1 <= 1'b1;
          end else begin
            done0_p1 <= 1'b1;
          end
          if (!wr_p0) begin
            if (win_p0) begin
              rdata1_p1 <= bus.sram_rd;
            end else begin
              rdata0_p1 <= bus.sram_rd;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Reset also masks the write strobe so a write aborted in ISSUE never reaches the array.
  assign bus.sram_we   = we_n_p1 | rst;
  assign bus.sram_addr = addr_p0;
  assign bus.sram_wd   = wd_p0;
  assign bus.gnt0      = gnt0_p1;
  assign bus.gnt1      = gnt1_p1;
  assign bus.done0     = done0_p1;
  assign bus.done1     = done1_p1;
  assign bus.rdata0    = rdata0_p1;
  assign bus.rdata1    = rdata1_p1;
  assign bus.busy      = busy_p1;

endmodule

// File: tb/tb_sram_arbiter2.sv
// Bench for sram_arbiter2: directed scenarios followed by randomized
// two-port traffic, checked against a transaction-level model of the
// memory contents, the round-robin pointer and the per-port read results.
module tb_sram_arbiter2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sram_arbiter2_if bus ();

  sram_arbiter2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 8x32 SRAM hanging off the arbiter.
  logic [31:0] sram_arr [8];
  always @(posedge clk) begin
    if (!bus.sram_we) sram_arr[bus.sram_addr] <= bus.sram_wd;
  end
  assign bus.sram_rd = sram_arr[bus.sram_addr];

  // Transaction-level reference state.
  logic [31:0] mem_m [8];
  logic [31:0] rdata_m [2];
  bit          last_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic done_of(input bit p);
    return p ? bus.done1 : bus.done0;
  endfunction

  task automatic model_reset();
    rdata_m[0] = 32'h0;
    rdata_m[1] = 32'h0;
    last_m     = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".gnt0"},  {31'd0, bus.gnt0},  32'd0);
    chk({tag, ".gnt1"},  {31'd0, bus.gnt1},  32'd0);
    chk({tag, ".done0"}, {31'd0, bus.done0}, 32'd0);
    chk({tag, ".done1"}, {31'd0, bus.done1}, 32'd0);
    chk({tag, ".rdata0"}, bus.rdata0, 32'h0);
    chk({tag, ".rdata1"}, bus.rdata1, 32'h0);
    chk({tag, ".sram_addr"}, {29'd0, bus.sram_addr}, 32'd0);
    chk({tag, ".sram_wd"}, bus.sram_wd, 32'h0);
    chk({tag, ".sram_we"}, {31'd0, bus.sram_we}, 32'd1);
    chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic drive(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.req0 = r0; bus.wr0 = w0; bus.addr0 = a0; bus.wd0 = d0;
    bus.req1 = r1; bus.wr1 = w1; bus.addr1 = a1; bus.wd1 = d1;
  endtask

  // One arbitration round starting at a negedge in IDLE; ends at the negedge of the done cycle.
  task automatic round(input string tag, input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       output bit win, output bit served);
    bit          w;
    logic [2:0]  a;
    logic [31:0] d;
    drive(r0, r1, w0, w1, a0, a1, d0, d1);
    served = r0 | r1;
    win    = (r0 && r1) ? ~last_m : r1;
    if (!served) begin
      step();
      chk({tag, ".idle_gnt"}, {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      chk({tag, ".idle_busy"}, {31'd0, bus.busy}, 32'd0);
      return;
    end
    w = win ? w1 : w0;
    a = win ? a1 : a0;
    d = win ? d1 : d0;
    step();
    chk({tag, ".gnt_win"}, {31'd0, gnt_of(win)}, 32'd1);
    chk({tag, ".gnt_other"}, {31'd0, gnt_of(~win)}, 32'd0);
    chk({tag, ".issue_we"}, {31'd0, bus.sram_we}, {31'd0, ~w});
    chk({tag, ".issue_addr"}, {29'd0, bus.sram_addr}, {29'd0, a});
    chk({tag, ".issue_busy"}, {31'd0, bus.busy}, 32'd1);
    if (win) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    step();
    chk({tag, ".complete_gnt"}, {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk({tag, ".complete_we"}, {31'd0, bus.sram_we}, 32'd1);
    chk({tag, ".complete_done"}, {30'd0, bus.done1, bus.done0}, 32'd0);
    if (w) mem_m[a] = d;
    else   rdata_m[win] = mem_m[a];
    last_m = win;
    step();
    chk({tag, ".done_win"}, {31'd0, done_of(win)}, 32'd1);
    chk({tag, ".done_other"}, {31'd0, done_of(~win)}, 32'd0);
    chk({tag, ".done_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".rdata0"}, bus.rdata0, rdata_m[0]);
    chk({tag, ".rdata1"}, bus.rdata1, rdata_m[1]);
  endtask

  initial begin
    bit          win;
    bit          served;
    bit          pend [2];
    bit          pw [2];
    logic [2:0]  pa [2];
    logic [31:0] pd [2];

    drive(0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0);
    model_reset();
    rst = 1'b1;
    step();
    step();
    check_reset("reset");

    // Both ports request while reset is still held: reset wins.
    drive(1, 1, 1, 1, 3'd0, 3'd4, 32'hA0A0_0000, 32'hB4B4_0004);
    step();
    chk("rst_prio.gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst_prio.busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    // Continuous dual requests: grants alternate 0,1,0,1 every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      round("alt", 1, 1, 1, 1, 3'd0, 3'd4, 32'hA0A0_0000, 32'hB4B4_0004, win, served);
      chk("alt.order", {31'd0, win}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // Port 1 fills all addresses, port 0 reads them back.
    for (int n = 0; n < 8; n++)
      round("fill", 0, 1, 0, 1, 3'd0, 3'(n), 32'h0, 32'h1111_1111 * n, win, served);
    for (int n = 0; n < 8; n++) begin
      round("readback", 1, 0, 0, 0, 3'(n), 3'd0, 32'h0, 32'h0, win, served);
      chk("readback.value", bus.rdata0, 32'h1111_1111 * n);
    end

    // Write then read of the same address.
    round("wr3", 1, 0, 1, 0, 3'd3, 3'd0, 32'hDEAD_BEEF, 32'h0, win, served);
    round("rd3", 1, 0, 0, 0, 3'd3, 3'd0, 32'h0, 32'h0, win, served);
    chk("rd3.value", bus.rdata0, 32'hDEAD_BEEF);

    // Port 1 read of address 7 leaves rdata0 alone.
    round("rd7", 0, 1, 0, 0, 3'd0, 3'd7, 32'h0, 32'h0, win, served);
    chk("rd7.value", bus.rdata1, 32'h7777_7777);
    chk("rd7.rdata0_kept", bus.rdata0, 32'hDEAD_BEEF);

    // Idle cycle with no request.
    round("none", 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, win, served);

    // Request from port 1 raised while port 0 is busy.
    drive(1, 0, 0, 0, 3'd1, 3'd0, 32'h0, 32'h0);
    step();
    chk("late.gnt0", {31'd0, bus.gnt0}, 32'd1);
    drive(0, 1, 0, 0, 3'd0, 3'd6, 32'h0, 32'h0);
    step();
    chk("late.no_gnt1_complete", {31'd0, bus.gnt1}, 32'd0);
    step();
    rdata_m[0] = mem_m[1];
    last_m = 1'b0;
    chk("late.done0", {31'd0, bus.done0}, 32'd1);
    chk("late.no_gnt1_idle", {31'd0, bus.gnt1}, 32'd0);
    chk("late.rdata0", bus.rdata0, rdata_m[0]);
    step();
    chk("late.gnt1", {31'd0, bus.gnt1}, 32'd1);
    bus.req1 = 1'b0;
    step();
    step();
    rdata_m[1] = mem_m[6];
    last_m = 1'b1;
    chk("late.done1", {31'd0, bus.done1}, 32'd1);
    chk("late.rdata1", bus.rdata1, rdata_m[1]);

    // Write to address 5 aborted by reset during ISSUE.
    drive(1, 0, 1, 0, 3'd5, 3'd0, 32'hBAD0_0005, 32'h0);
    step();
    chk("abort_wr.gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("abort_wr.we_issue", {31'd0, bus.sram_we}, 32'd0);
    bus.req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_wr.we_masked", {31'd0, bus.sram_we}, 32'd1);
    step();
    rst = 1'b0;
    model_reset();
    check_reset("abort_wr");
    step();
    chk("abort_wr.no_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    step();
    chk("abort_wr.no_done_late", {30'd0, bus.done1, bus.done0}, 32'd0);
    round("abort_wr.rd5", 1, 0, 0, 0, 3'd5, 3'd0, 32'h0, 32'h0, win, served);
    chk("abort_wr.prior", bus.rdata0, 32'h5555_5555);

    // Read aborted by reset during COMPLETE.
    drive(0, 1, 0, 0, 3'd0, 3'd2, 32'h0, 32'h0);
    step();
    bus.req1 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_reset("abort_rd");
    step();
    chk("abort_rd.no_done", {30'd0, bus.done1, bus.done0}, 32'd0);

    // Randomized two-port traffic; a losing requester keeps its payload until granted.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) != 0) begin
          pend[p] = 1'b1;
          pw[p]   = 1'($urandom_range(0, 1));
          pa[p]   = 3'($urandom_range(0, 7));
          pd[p]   = $urandom;
        end
      end
      round("rand", pend[0], pend[1], pw[0], pw[1], pa[0], pa[1], pd[0], pd[1], win, served);
      if (served) pend[win] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
